// File: rtl/mcp4822_pkg.sv
// Shared definitions for the MCP4822 DAC transmit path.
// State encoding, frame layout and frame builder.
package mcp4822_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_LDAC_GAP,
    ST_LDAC_LOW
  } state_t;

  localparam int FRAME_LEN = 16;
  localparam int BIT_AB    = 15;
  localparam int BIT_GA    = 13;
  localparam int BIT_SHDN  = 12;
  localparam int DATA_MSB  = 11;

  function automatic logic [FRAME_LEN-1:0] make_frame(
    input logic        ab,
    input logic        ga,
    input logic        shdn,
    input logic [11:0] data
  );
    logic [FRAME_LEN-1:0] f;
    f               = '0;
    f[BIT_AB]       = ab;
    f[BIT_GA]       = ga;
    f[BIT_SHDN]     = shdn;
    f[DATA_MSB:0]   = data;
    return f;
  endfunction

endpackage

// File: rtl/mcp4822_spi_tx_sck_div.sv
// SCK half-period divider for the MCP4822 transmitter.
// Emits one-cycle strikes at the end of each low/high phase.
module spi_sck_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [HW-1:0] HALF_END = HW'(CLK_DIV - 1);

  logic [HW-1:0] hcnt;
  logic          phase;
  logic          half_end;

  assign half_end = en && (hcnt == HALF_END);
  assign sck_rise = half_end && !phase;
  assign sck_fall = half_end && phase;

  // Count out each half-period; phase restarts low whenever disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt  <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      hcnt  <= '0;
      phase <= 1'b0;
    end else if (half_end) begin
      hcnt  <= '0;
      phase <= !phase;
    end else begin
      hcnt  <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/mcp4822_spi_tx.sv
// MCP4822 write-frame serialiser with LDAC strobe.
// One-deep pending buffer absorbs samples arriving mid-frame.
module mcp4822_spi_tx
  import mcp4822_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   LDAC_CYC = 16,
  parameter logic CHANNEL  = 1'b0,
  parameter logic GAIN_1X  = 1'b1,
  parameter logic SHDN_N   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_DATA,
  input  logic        i_DV,
  output logic        SCK,
  output logic        MOSI,
  output logic        CS,
  output logic        LDAC,
  output logic        o_BUSY,
  output logic        o_DROP
);

  localparam int CMAX = (CLK_DIV > LDAC_CYC) ? CLK_DIV : LDAC_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LDAC_END = CW'(LDAC_CYC - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_LEN - 1);

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [3:0]     bit_cnt, bit_cnt_nx;
  logic [15:0]    sreg, sreg_nx;
  logic           sck_r, sck_nx;
  logic           mosi_r, mosi_nx;
  logic           cs_r, cs_nx;
  logic           ldac_r, ldac_nx;
  logic           busy_r, busy_nx;
  logic           drop_r, drop_nx;
  logic           pend, pend_nx;
  logic [11:0]    pend_data, pend_data_nx;
  logic           dv_q;
  logic           rise;
  logic           sck_rise, sck_fall;
  logic [15:0]    launch_frame;

  assign rise = i_DV && !dv_q;
  assign launch_frame = make_frame(CHANNEL, GAIN_1X, SHDN_N,
                                   pend ? pend_data : i_DATA);

  spi_sck_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_div (
    .clk      (clk),
    .rst      (rst),
    .en       (state == ST_SHIFT),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // Edge detector; starts high so a level present at reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dv_q <= 1'b1;
    else     dv_q <= i_DV;
  end

  // Next-state, datapath and output decisions.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    bit_cnt_nx   = bit_cnt;
    sreg_nx      = sreg;
    sck_nx       = sck_r;
    mosi_nx      = mosi_r;
    cs_nx        = cs_r;
    ldac_nx      = ldac_r;
    busy_nx      = busy_r;
    drop_nx      = 1'b0;
    pend_nx      = pend;
    pend_data_nx = pend_data;

    case (state)
      ST_IDLE: begin
        if (pend || rise) begin
          sreg_nx    = launch_frame;
          mosi_nx    = launch_frame[FRAME_LEN-1];
          cs_nx      = 1'b0;
          busy_nx    = 1'b1;
          cnt_nx     = '0;
          bit_cnt_nx = '0;
          state_nx   = ST_CS_SETUP;
          if (pend) begin
            pend_nx = rise;
            if (rise) pend_data_nx = i_DATA;
          end
        end
      end
      ST_CS_SETUP: begin
        if (cnt == DIV_END) begin
          cnt_nx   = '0;
          state_nx = ST_SHIFT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sck_rise) sck_nx = 1'b1;
        if (sck_fall) begin
          sck_nx = 1'b0;
          if (bit_cnt == LAST_BIT) begin
            mosi_nx  = 1'b0;
            cnt_nx   = '0;
            state_nx = ST_CS_HOLD;
          end else begin
            sreg_nx    = {sreg[14:0], 1'b0};
            mosi_nx    = sreg[14];
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
      ST_CS_HOLD: begin
        if (cnt == DIV_END) begin
          cnt_nx   = '0;
          cs_nx    = 1'b1;
          state_nx = ST_LDAC_GAP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_LDAC_GAP: begin
        if (cnt == LDAC_END) begin
          cnt_nx   = '0;
          ldac_nx  = 1'b0;
          state_nx = ST_LDAC_LOW;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_LDAC_LOW: begin
        if (cnt == LDAC_END) begin
          cnt_nx   = '0;
          ldac_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nx   = '0;
        sck_nx   = 1'b0;
        mosi_nx  = 1'b0;
        cs_nx    = 1'b1;
        ldac_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase

    if (state != ST_IDLE && rise) begin
      pend_nx      = 1'b1;
      pend_data_nx = i_DATA;
      drop_nx      = pend;
    end
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      sreg      <= '0;
      sck_r     <= 1'b0;
      mosi_r    <= 1'b0;
      cs_r      <= 1'b1;
      ldac_r    <= 1'b1;
      busy_r    <= 1'b0;
      drop_r    <= 1'b0;
      pend      <= 1'b0;
      pend_data <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      sreg      <= sreg_nx;
      sck_r     <= sck_nx;
      mosi_r    <= mosi_nx;
      cs_r      <= cs_nx;
      ldac_r    <= ldac_nx;
      busy_r    <= busy_nx;
      drop_r    <= drop_nx;
      pend      <= pend_nx;
      pend_data <= pend_data_nx;
    end
  end

  assign SCK    = sck_r;
  assign MOSI   = mosi_r;
  assign CS     = cs_r;
  assign LDAC   = ldac_r;
  assign o_BUSY = busy_r;
  assign o_DROP = drop_r;

endmodule

// File: tb/tb_mcp4822_spi_tx.sv
// Bench for mcp4822_spi_tx: timing-level reference model feeding a
// scoreboard, monitor decodes the SPI/LDAC waveforms and compares.
module tb_mcp4822_spi_tx;

  localparam int CD   = 4;
  localparam int LC   = 16;
  localparam int FREE = 34 * CD + 2 * LC + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] i_data = '0;
  logic        i_dv = 1'b0;
  logic        sck, mosi, cs, ldac, busy, drop;

  logic [11:0] data2 = '0;
  logic        dv2 = 1'b0;
  logic        sck2, mosi2, cs2, ldac2, busy2, drop2;

  mcp4822_spi_tx #(
    .CLK_DIV(CD), .LDAC_CYC(LC),
    .CHANNEL(1'b0), .GAIN_1X(1'b1), .SHDN_N(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .i_DATA(i_data), .i_DV(i_dv),
    .SCK(sck), .MOSI(mosi), .CS(cs), .LDAC(ldac),
    .o_BUSY(busy), .o_DROP(drop)
  );

  mcp4822_spi_tx #(
    .CLK_DIV(CD), .LDAC_CYC(LC),
    .CHANNEL(1'b1), .GAIN_1X(1'b0), .SHDN_N(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .i_DATA(data2), .i_DV(dv2),
    .SCK(sck2), .MOSI(mosi2), .CS(cs2), .LDAC(ldac2),
    .o_BUSY(busy2), .o_DROP(drop2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] frame;
    int          launch;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];

  // Reference model: a launch occupies the link for FREE cycles.
  int          cyc = 0;
  logic        m_prev = 1'b1;
  logic        m_rise;
  bit          m_pend = 0;
  logic [11:0] m_pw = '0;
  int          m_free = 0;

  function automatic logic [15:0] spec_frame(input logic [11:0] d);
    return {1'b0, 1'b0, 1'b1, 1'b1, d};
  endfunction

  task automatic m_launch(input logic [11:0] d);
    exp_t e;
    e.frame  = spec_frame(d);
    e.launch = cyc;
    exp_q.push_back(e);
    m_free = cyc + FREE;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_rise = i_dv && !m_prev;
      m_prev = i_dv;
      if (cyc >= m_free && m_pend) begin
        m_launch(m_pw);
        m_pend = m_rise;
        if (m_rise) m_pw = i_data;
      end else if (cyc >= m_free && m_rise) begin
        m_launch(i_data);
      end else if (m_rise) begin
        if (m_pend) drop_q.push_back(cyc);
        m_pend = 1;
        m_pw = i_data;
      end
    end
  end

  // Monitor: decode the waveforms and check against the scoreboard.
  logic        p_cs = 1'b1, p_sck = 1'b0, p_ldac = 1'b1, p_busy = 1'b0;
  int          t_cf, t_cr, t_lf, t_br, nbits;
  logic [15:0] shv;
  bit          sck_bad;
  int          frames = 0;
  int          drops_seen = 0;
  exp_t        e_pop;

  always @(negedge clk) begin
    if (!rst) begin
      if (p_cs && !cs) begin
        t_cf = cyc; nbits = 0; shv = '0; sck_bad = 0;
      end
      if (!cs && !p_sck && sck) begin
        if (cyc != t_cf + 2 * CD + 2 * CD * nbits) sck_bad = 1;
        shv = {shv[14:0], mosi};
        nbits++;
      end
      if (!p_cs && cs) begin
        t_cr = cyc;
        frames++;
        chk("frame_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_pop = exp_q.pop_front();
          chk("frame_bits", shv, e_pop.frame);
          chk("frame_launch", t_cf, e_pop.launch);
        end
        chk("bit_count", nbits, 16);
        chk("sck_timing", sck_bad, 0);
        chk("cs_low_width", t_cr - t_cf, 34 * CD);
      end
      if (p_ldac && !ldac) begin
        t_lf = cyc;
        chk("ldac_gap", t_lf - t_cr, LC);
      end
      if (!p_ldac && ldac) chk("ldac_width", cyc - t_lf, LC);
      if (!p_busy && busy) t_br = cyc;
      if (p_busy && !busy) chk("busy_width", cyc - t_br, 34 * CD + 2 * LC);
      if (drop) begin
        drops_seen++;
        chk("drop_expected", (drop_q.size() > 0), 1);
        if (drop_q.size() > 0) chk("drop_cycle", cyc, drop_q.pop_front());
      end
      p_cs = cs; p_sck = sck; p_ldac = ldac; p_busy = busy;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse(input logic [11:0] d, input int hi);
    @(posedge clk); #2;
    i_data = d;
    i_dv = 1'b1;
    repeat (hi) @(posedge clk);
    #2 i_dv = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_cs", cs, 1'b1);
    chk("rst_sck", sck, 1'b0);
    chk("rst_ldac", ldac, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    exp_q.delete();
    drop_q.delete();
    m_pend = 0; m_free = 0; m_prev = 1'b1;
    p_cs = 1'b1; p_sck = 1'b0; p_ldac = 1'b1; p_busy = 1'b0;
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  int          f0, d0, gap, hi, n2, lowc;
  logic [11:0] rd;
  logic [15:0] f2;
  logic        ps2;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("init_cs", cs, 1'b1);
    chk("init_sck", sck, 1'b0);
    chk("init_mosi", mosi, 1'b0);
    chk("init_ldac", ldac, 1'b1);
    chk("init_busy", busy, 1'b0);
    chk("init_drop", drop, 1'b0);
    rst = 1'b0;
    idle(5);

    f0 = frames;
    pulse(12'hA5C, 200);
    idle(20);
    chk("one_frame_held_dv", frames - f0, 1);

    f0 = frames; d0 = drops_seen;
    pulse(12'h456, 3);
    idle(45);
    pulse(12'h123, 3);
    idle(400);
    chk("pend_two_frames", frames - f0, 2);
    chk("pend_no_drop", drops_seen - d0, 0);

    f0 = frames; d0 = drops_seen;
    pulse(12'h111, 3);
    idle(20);
    pulse(12'h222, 3);
    idle(20);
    pulse(12'h333, 3);
    idle(400);
    chk("triple_two_frames", frames - f0, 2);
    chk("triple_one_drop", drops_seen - d0, 1);

    @(posedge clk); #2;
    i_data = 12'h5A5;
    i_dv = 1'b1;
    repeat (63) @(posedge clk);
    f0 = frames;
    do_reset(3);
    idle(200);
    chk("no_frame_after_rst", frames - f0, 0);
    chk("cs_high_after_rst", cs, 1'b1);
    #2 i_dv = 1'b0;
    pulse(12'h789, 3);
    idle(200);
    chk("frame_after_new_rise", frames - f0, 1);

    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(260, 2);
      hi = $urandom_range(gap - 1, 1);
      rd = 12'($urandom);
      pulse(rd, hi);
      idle(gap - hi);
    end
    idle(400);

    @(posedge clk); #2;
    data2 = 12'hFFF;
    dv2 = 1'b1;
    n2 = 0; f2 = '0; ps2 = 1'b0; lowc = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!cs2 && !ps2 && sck2) begin
        f2 = {f2[14:0], mosi2};
        n2++;
      end
      if (!ldac2) lowc++;
      if (drop2) lowc = lowc + 1000;
      ps2 = sck2;
    end
    chk("frame_b_bits", n2, 16);
    chk("frame_b_value", f2, 16'h8FFF);
    chk("frame_b_ldac", lowc, LC);
    chk("frame_b_busy_end", busy2, 1'b0);
    dv2 = 1'b0;

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("drop_queue_empty", drop_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcp4822_spi_tx.md
# mcp4822_spi_tx

SPI transmit master for the MCP4822 dual 12-bit DAC; the stage directly downstream of the MCP3202 ADC master. It takes each 12-bit sample marked by the ADC's data-valid level and serialises it as one 16-bit MCP4822 write frame. It then pulses LDAC to update the analog output. Runs on the same 125 MHz clock and is idle for most of each 20 µs sample period.

## Interface
- CLK_DIV, 4: system clocks per SCK half-period (4 → 15.6 MHz SCK); functional for ≥1, must be ≥4 at 125 MHz (DAC max 20 MHz)
- LDAC_CYC, 16: clocks from CS high to LDAC low, and LDAC low width (16 → 128 ns, ≥100 ns)
- CHANNEL, 0: frame bit 15, A/B select (0 = DAC A)
- GAIN_1X, 1: frame bit 13, GA (1 = 1x)
- SHDN_N, 1: frame bit 12 (1 = output active)
- clk  in  1  125 MHz system clock
- rst  in  1  asynchronous, active-high reset
- i_DATA  in  12  sample word, stable while i_DV high
- i_DV  in  1  data-valid level; a rising edge marks a new sample
- SCK  out  1  SPI clock, idles low (mode 0,0)
- MOSI  out  1  data to DAC SDI
- CS  out  1  chip select, active low
- LDAC  out  1  latch strobe, active low
- o_BUSY  out  1  high from launch until return to IDLE
- o_DROP  out  1  one-cycle pulse when a pending sample is overwritten

## Operation
- Edge detect: register dv_q <= i_DV. Rising edge = i_DV & ~dv_q. dv_q resets to 1, so a level already high at reset release is ignored.
- Frame = {CHANNEL, 1'b0, GAIN_1X, SHDN_N, i_DATA}, MSB first. Data is captured at the detecting edge.
- Pending buffer, one deep:
  - A rising edge while not in IDLE stores the word and sets pend.
  - If pend is already set, the word overwrites it and o_DROP pulses.
- IDLE: CS=1, SCK=0, MOSI=0, LDAC=1, o_BUSY=0.
  - On rising edge, or pend set: load the shift register, CS<=0, MOSI<=bit15, o_BUSY<=1, go to CS_SETUP.
  - If pend was the source, clear pend.
  - If pend and a new edge coincide in IDLE, pend launches and the new word becomes pend (no drop).
- CS_SETUP: hold CLK_DIV cycles, then go to SHIFT.
- SHIFT: 16 bits, each CLK_DIV cycles SCK low, then CLK_DIV cycles SCK high.
  - DAC samples on the SCK rising edge.
  - MOSI advances to the next bit when SCK returns low.
  - After the 16th high phase: SCK<=0, MOSI<=0, go to CS_HOLD.
- CS_HOLD: CLK_DIV cycles with CS=0, then CS<=1, go to LDAC_GAP.
- LDAC_GAP: LDAC_CYC cycles, then LDAC<=0, go to LDAC_LOW.
- LDAC_LOW: LDAC_CYC cycles, then LDAC<=1, o_BUSY<=0, go to IDLE.
- Unused state encodings go to IDLE.
- Reset (asynchronous, may hit mid-frame): CS=1, SCK=0, MOSI=0, LDAC=1, o_BUSY=0, o_DROP=0, pend=0, dv_q=1, counters=0, state=IDLE. A truncated frame is not resumed.

## Timing
- CS falls registered one cycle after the edge that samples the i_DV rise.
- CS low duration is CLK_DIV*34 cycles (136 with defaults).
- o_BUSY high duration is CLK_DIV*34 + 2*LDAC_CYC cycles (168 with defaults). This fits well inside the 2500-cycle sample period.
- First SCK rise occurs CLK_DIV*2 cycles after CS falls. Last SCK fall precedes CS rise by CLK_DIV cycles.
- CS stays high for at least 2*LDAC_CYC cycles between frames (≥15 ns tCSH).
- A pending frame launches on the first IDLE cycle, so IDLE lasts exactly one cycle.

## Structure
- Shared package mcp4822_pkg holds:
  - state encoding (IDLE, CS_SETUP, SHIFT, CS_HOLD, LDAC_GAP, LDAC_LOW)
  - frame bit positions (A/B = 15, GA = 13, SHDN = 12, data = 11:0)
  - the 16-bit frame length constant
- One sub-module, spi_sck_div: half-period counter and phase toggle, enabled in SHIFT, giving sck_rise/sck_fall strikes. The FSM, shift register and pending logic stay in the top level.

## Test plan
- Reset, then i_DV rise with i_DATA=0xA5C → MOSI bits across 16 SCK rises = 0x3A5C. CS low 136 cycles, SCK period 8 cycles, LDAC low 16 cycles starting 16 cycles after CS rise, o_BUSY high 168 cycles.
- Hold i_DV high for 200 cycles → exactly one frame; no retrigger.
- Second rise at cycle 50 of a frame (0x123) → second frame starts the cycle after o_BUSY falls, shifting 0x3123. o_DROP stays 0.
- Three rises within one frame (0x111, 0x222, 0x333) → o_DROP pulses once. The next frame carries 0x333.
- Assert rst during SHIFT bit 7 → outputs immediately CS=1, SCK=0, LDAC=1, o_BUSY=0. After release with i_DV held high, no frame until the next i_DV rise.
- CHANNEL=1, GAIN_1X=0, SHDN_N=0, i_DATA=0xFFF → frame 0x8FFF.
